// File: rtl/fw_inference_ctrl.sv
// Sequencer for the FW_logic inference datapath: collects a serial pixel
// stream into a flat vector, pulses FW_logic reset, enables it for a fixed
// window, captures the predicted digit and hands it out on valid/ready.
module fw_inference_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int VECTOR_SIZE = 784,
    parameter int RST_CYCLES  = 2,
    parameter int NN_LATENCY  = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             s_pixel_data,
    input  logic                              s_pixel_valid,
    input  logic                              s_pixel_last,
    output logic                              s_pixel_ready,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] nn_pixels,
    output logic                              nn_en,
    output logic                              nn_reset,
    input  logic [3:0]                        nn_digit,
    output logic [3:0]                        m_digit,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              busy,
    output logic                              frame_err
);

    localparam int PIX_W  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int PH_MAX = (RST_CYCLES > NN_LATENCY) ? RST_CYCLES : NN_LATENCY;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(VECTOR_SIZE - 1);
    localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  RUN_LAST = PH_W'(NN_LATENCY - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        NN_RST = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [PIX_W-1:0] pix_cnt, pix_cnt_nxt;
    logic [PH_W-1:0]  ph_cnt, ph_cnt_nxt;
    logic             nn_reset_nxt, nn_en_nxt, m_valid_nxt, frame_err_nxt;
    logic [3:0]       m_digit_nxt;
    logic             beat;

    // Ready only in LOAD, and held off while the post-reset nn_reset is still up
    assign s_pixel_ready = (state == LOAD) && !nn_reset;
    assign busy          = (state != LOAD);
    assign beat          = s_pixel_valid && s_pixel_ready;

    // Next-state and next-output decode; registered outputs hold by default
    always_comb begin
        state_nxt     = state;
        pix_cnt_nxt   = pix_cnt;
        ph_cnt_nxt    = ph_cnt;
        nn_reset_nxt  = nn_reset;
        nn_en_nxt     = nn_en;
        m_valid_nxt   = m_valid;
        m_digit_nxt   = m_digit;
        frame_err_nxt = 1'b0;
        unique case (state)
            LOAD: begin
                nn_reset_nxt = 1'b0;
                if (beat) begin
                    if (pix_cnt == PIX_LAST) begin
                        // Full frame: a missing last flag is tolerated
                        pix_cnt_nxt  = '0;
                        ph_cnt_nxt   = '0;
                        nn_reset_nxt = 1'b1;
                        state_nxt    = NN_RST;
                    end else if (s_pixel_last) begin
                        // Short frame: drop it, keep whatever pixels landed
                        pix_cnt_nxt   = '0;
                        frame_err_nxt = 1'b1;
                    end else begin
                        pix_cnt_nxt = pix_cnt + 1'b1;
                    end
                end
            end
            NN_RST: begin
                if (ph_cnt == RST_LAST) begin
                    ph_cnt_nxt   = '0;
                    nn_reset_nxt = 1'b0;
                    nn_en_nxt    = 1'b1;
                    state_nxt    = RUN;
                end else begin
                    ph_cnt_nxt = ph_cnt + 1'b1;
                end
            end
            RUN: begin
                if (ph_cnt == RUN_LAST) begin
                    ph_cnt_nxt  = '0;
                    nn_en_nxt   = 1'b0;
                    m_digit_nxt = nn_digit;
                    m_valid_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    ph_cnt_nxt = ph_cnt + 1'b1;
                end
            end
            DONE: begin
                if (m_ready) begin
                    m_valid_nxt = 1'b0;
                    state_nxt   = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // State, counters and control outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            pix_cnt   <= '0;
            ph_cnt    <= '0;
            nn_reset  <= 1'b1;
            nn_en     <= 1'b0;
            m_valid   <= 1'b0;
            m_digit   <= 4'd0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pix_cnt   <= pix_cnt_nxt;
            ph_cnt    <= ph_cnt_nxt;
            nn_reset  <= nn_reset_nxt;
            nn_en     <= nn_en_nxt;
            m_valid   <= m_valid_nxt;
            m_digit   <= m_digit_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Pixel vector: beat k fills byte slot k counted from the MSB end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nn_pixels <= '0;
        end else if (beat) begin
            nn_pixels[DATA_WIDTH*(VECTOR_SIZE-int'(pix_cnt))-1 -: DATA_WIDTH] <= s_pixel_data;
        end
    end

endmodule
